// File: rtl/demo_timeline.sv
// demo_timeline: frame-rate sequencer for the racing-the-beam VGA demo.
// It counts ticks (frame pulses, or step edges while paused) into a frame
// counter with an optional half-rate fractional bit. It also derives the part,
// beat, envelope, part-change and noise values used by the pixel/colour stage.
// Note: frame_counter must be at least 10 bits wide, because part is taken
// from bits [9:7].
module demo_timeline #(
  parameter int FRAME_BITS = 12,
  parameter int LOOP_START = 0,
  parameter int LOOP_END   = 2**FRAME_BITS - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  half_rate,
  output logic [FRAME_BITS-1:0] frame_counter,
  output logic                  frame_frac,
  output logic [2:0]            part,
  output logic [6:0]            part_frame,
  output logic                  beat_1_3,
  output logic [4:0]            envelope_b,
  output logic                  part_change,
  output logic [7:0]            noise
);

  localparam logic [FRAME_BITS-1:0] LOOP_START_V = FRAME_BITS'(LOOP_START);
  localparam logic [FRAME_BITS-1:0] LOOP_END_V   = FRAME_BITS'(LOOP_END);

  // State registers
  logic [FRAME_BITS-1:0] frame_reg, frame_next;
  logic                  frac_reg, frac_next;
  logic                  step_d_reg;
  logic                  part_change_reg, part_change_next;
  logic [7:0]            noise_reg, noise_next;

  // Tick and advance helpers
  logic                  step_rise;
  logic                  tick;
  logic                  carry;
  logic [FRAME_BITS:0]   timer_reg;
  logic [FRAME_BITS:0]   timer_inc;
  logic [7:0]            noise_shifted;

  // The combined timer is {frame_counter, frac}. At half rate it is advanced
  // as one (FRAME_BITS+1)-bit value.
  assign timer_reg = {frame_reg, frac_reg};
  assign timer_inc = timer_reg + (FRAME_BITS+1)'(1);

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left. Bit 0 takes the feedback,
  // and the other bits take their lower neighbour.
  assign noise_shifted[0] = noise_reg[7] ^ noise_reg[5] ^ noise_reg[4] ^ noise_reg[3];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
      assign noise_shifted[gi] = noise_reg[gi-1];
    end
  endgenerate

  // Tick generation and the next-state computation for the counter, LFSR and
  // part-change pulse.
  always_comb begin
    step_rise        = step & ~step_d_reg;
    tick             = (~pause & frame_start) | (pause & step_rise);
    carry            = half_rate ? frac_reg : 1'b1;
    frame_next       = frame_reg;
    frac_next        = frac_reg;
    noise_next       = noise_reg;
    part_change_next = 1'b0;
    if (tick) begin
      if (carry && (frame_reg == LOOP_END_V)) begin
        // Loop-back always realigns the timer to a whole frame.
        frame_next = LOOP_START_V;
        frac_next  = 1'b0;
      end else if (half_rate) begin
        {frame_next, frac_next} = timer_inc;
      end else begin
        frame_next = frame_reg + FRAME_BITS'(1);
      end
      noise_next       = noise_shifted;
      part_change_next = (frame_next[9:7] != frame_reg[9:7]);
    end
  end

  // State update. Reset overrides everything, so a frame pulse that arrives
  // while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_reg       <= '0;
      frac_reg        <= 1'b0;
      step_d_reg      <= 1'b0;
      part_change_reg <= 1'b0;
      noise_reg       <= 8'h01;
    end else begin
      frame_reg       <= frame_next;
      frac_reg        <= frac_next;
      step_d_reg      <= step;
      part_change_reg <= part_change_next;
      noise_reg       <= noise_next;
    end
  end

  // The derived outputs are decoded combinationally from the registered timer.
  always_comb begin
    frame_counter = frame_reg;
    frame_frac    = frac_reg;
    part          = frame_reg[9:7];
    part_frame    = frame_reg[6:0];
    beat_1_3      = (timer_reg[5:4] == 2'b10);
    envelope_b    = 5'd31 - {timer_reg[3:0], 1'b0};
    part_change   = part_change_reg;
    noise         = noise_reg;
  end

endmodule

// File: tb/tb_demo_timeline.sv
// Bench for demo_timeline. It runs two instances: the default full-range loop
// and a short 4..10 loop. Both are checked every cycle against an integer
// timer model, and directed scenarios pin the model with literal values.
module tb_demo_timeline;

  logic clk = 1'b0;
  logic reset, frame_start, pause, step, half_rate;

  logic [11:0] fc_a, fc_b;
  logic        fr_a, fr_b, beat_a, beat_b, pc_a, pc_b;
  logic [2:0]  part_a, part_b;
  logic [6:0]  pf_a, pf_b;
  logic [4:0]  env_a, env_b;
  logic [7:0]  noise_a, noise_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state: timer = 2*frame_counter + frac
  int   ta, tb;
  bit   m_pc_a, m_pc_b;
  bit   m_step_d;
  int   m_idx;
  logic [7:0] seq [255];

  always #5 clk = ~clk;

  demo_timeline u_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pause(pause),
    .step(step), .half_rate(half_rate),
    .frame_counter(fc_a), .frame_frac(fr_a), .part(part_a), .part_frame(pf_a),
    .beat_1_3(beat_a), .envelope_b(env_a), .part_change(pc_a), .noise(noise_a)
  );

  demo_timeline #(.FRAME_BITS(12), .LOOP_START(4), .LOOP_END(10)) u_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pause(pause),
    .step(step), .half_rate(half_rate),
    .frame_counter(fc_b), .frame_frac(fr_b), .part(part_b), .part_frame(pf_b),
    .beat_1_3(beat_b), .envelope_b(env_b), .part_change(pc_b), .noise(noise_b)
  );

  function automatic int adv(int t, bit hr, int ls, int le);
    int  fc    = t >> 1;
    int  fr    = t & 1;
    bit  carry = hr ? fr[0] : 1'b1;
    if (carry && fc == le) return ls * 2;
    if (hr) return (t + 1) % 8192;
    return ((fc + 1) % 4096) * 2 + fr;
  endfunction

  function automatic int part_of(int t);
    return (t >> 8) & 7;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: it works on integer timers and advances on each tick.
  always @(posedge clk) begin
    bit tick;
    int na, nb;
    if (reset) begin
      ta = 0; tb = 0; m_pc_a = 0; m_pc_b = 0; m_step_d = 0; m_idx = 0;
    end else begin
      tick = (!pause && frame_start) || (pause && step && !m_step_d);
      m_step_d = step;
      m_pc_a = 0; m_pc_b = 0;
      if (tick) begin
        na = adv(ta, half_rate, 0, 4095);
        nb = adv(tb, half_rate, 4, 10);
        m_pc_a = part_of(na) != part_of(ta);
        m_pc_b = part_of(nb) != part_of(tb);
        ta = na; tb = nb;
        m_idx = (m_idx + 1) % 255;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_frame_counter", fc_a, ta >> 1);
      check("a_frame_frac", fr_a, ta & 1);
      check("a_part", part_a, part_of(ta));
      check("a_part_frame", pf_a, (ta >> 1) & 127);
      check("a_beat_1_3", beat_a, ((ta >> 4) & 3) == 2);
      check("a_envelope_b", env_a, 31 - 2 * (ta & 15));
      check("a_part_change", pc_a, m_pc_a);
      check("a_noise", noise_a, seq[m_idx]);
      check("b_frame_counter", fc_b, tb >> 1);
      check("b_frame_frac", fr_b, tb & 1);
      check("b_part", part_b, part_of(tb));
      check("b_part_frame", pf_b, (tb >> 1) & 127);
      check("b_beat_1_3", beat_b, ((tb >> 4) & 3) == 2);
      check("b_envelope_b", env_b, 31 - 2 * (tb & 15));
      check("b_part_change", pc_b, m_pc_b);
      check("b_noise", noise_b, seq[m_idx]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;
    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++) begin
      prev   = seq[i-1];
      seq[i] = {prev[6:0], prev[7] ^ prev[5] ^ prev[4] ^ prev[3]};
    end

    reset = 1'b1; frame_start = 1'b0; pause = 1'b0; step = 1'b0; half_rate = 1'b0;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_counter", fc_a, 0);
    check("rst_frac", fr_a, 0);
    check("rst_part", part_a, 0);
    check("rst_envelope", env_a, 31);
    check("rst_noise", noise_a, 8'h01);
    check("rst_part_change", pc_a, 0);
    cyc(1);

    // 128 full-rate frames: part 0 -> 1 with a one-cycle part_change
    repeat (127) pulse();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    @(negedge clk);
    check("f128_counter", fc_a, 128);
    check("f128_part", part_a, 1);
    check("f128_part_change_hi", pc_a, 1);
    cyc(1);
    @(negedge clk);
    check("f128_part_change_lo", pc_a, 0);
    cyc(1);

    // Half rate from zero
    do_reset();
    half_rate = 1'b1;
    pulse();
    check("hr1_frac", fr_a, 1);
    check("hr1_counter", fc_a, 0);
    pulse();
    check("hr2_frac", fr_a, 0);
    check("hr2_counter", fc_a, 1);
    repeat (30) pulse();
    check("t32_beat", beat_a, 1);
    repeat (15) pulse();
    check("t47_envelope", env_a, 1);
    half_rate = 1'b0;

    // Pause ignores frames; a held step gives exactly one advance
    do_reset();
    pause = 1'b1;
    repeat (10) pulse();
    check("pause_counter", fc_a, 0);
    check("pause_noise", noise_a, 8'h01);
    step = 1'b1;
    cyc(3);
    step = 1'b0;
    cyc(1);
    check("step_counter", fc_a, 1);
    check("step_noise", noise_a, 8'h02);
    pause = 1'b0;

    // Short loop 4..10 on instance b
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      pulse();
      check("loop_count", fc_b, i);
    end
    pulse();
    check("loop_back", fc_b, 4);
    check("loop_back_frac", fr_b, 0);
    repeat (6) pulse();
    half_rate = 1'b1;
    pulse();
    check("loop_hr_frac", fr_b, 1);
    check("loop_hr_counter", fc_b, 10);
    pulse();
    check("loop_hr_back", fc_b, 4);
    check("loop_hr_back_frac", fr_b, 0);
    half_rate = 1'b0;

    // Reset together with a frame pulse at counter 200
    do_reset();
    repeat (200) pulse();
    check("pre_reset_counter", fc_a, 200);
    reset = 1'b1;
    frame_start = 1'b1;
    cyc(1);
    reset = 1'b0;
    frame_start = 1'b0;
    cyc(3);
    check("drop_counter", fc_a, 0);
    check("drop_noise", noise_a, 8'h01);

    // Natural wrap 4095 -> 0 with a tick every cycle
    frame_start = 1'b1;
    cyc(4096);
    frame_start = 1'b0;
    cyc(1);
    check("wrap_counter", fc_a, 0);

    // Randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 1499) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      step        = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) half_rate = ~half_rate;
      cyc(1);
    end
    reset = 1'b0; frame_start = 1'b0; step = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
